aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Iterative AES-128 key expansion engine that takes a 128-bit cipher key over a valid/ready handshake and produces the full 11-round-key schedule (1408 bits) after a fixed, parameter-dependent number of cycles. It replaces the chain of fixed-round registered expansion stages with one engine. That engine is configurable between area (1 round/cycle) and latency (up to 10 rounds/cycle). It sits ahead of the AES-GCM cipher pipelines and feeds the `[0:1407]` schedule bus they consume.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- `clk` input, 1 bit: clock; all state is on the rising edge.
- `rst` input, 1 bit: reset; asynchronous, active-high.
- `i_valid` input, 1 bit: `i_key` is presented.
- `o_ready` output, 1 bit: the engine can accept a key this cycle.
- `i_key` input, `[0:127]`: cipher key; bit 0 is the MSB of byte 0.
- `o_valid` output, 1 bit: `o_key_schedule` is complete and stable.
- `i_ready` input, 1 bit: downstream accepts the schedule.
- `o_key_schedule` output, `[0:1407]`: round key k occupies bits `[128k : 128k+127]`.
- `o_busy` output, 1 bit: expansion is in progress.
- The following ports exist only with `AES_KEY_EXPANDER_STREAM_EN`:
  - `o_rk_valid` output, 1 bit: a round key has been produced.
  - `o_rk_idx` output, 4 bits: round number (1–10) of `o_rk`.
  - `o_rk` output, `[0:127]`: the produced round key.

## Operation
- The engine has three states: IDLE, EXPAND and DONE.
- The step count is `STEPS = 10 / ROUNDS_PER_CYCLE`, and a step counter runs from 0 to `STEPS-1`.
- `o_ready` is 1 in IDLE, and also in DONE when `i_ready` is 1. The DONE path is combinational from `i_ready`, which allows back-to-back keys.
- **Accept.** A key is accepted when `i_valid & o_ready`:
  - `i_key` is loaded into schedule bits `[0:127]`.
  - All remaining schedule bits are cleared to 0.
  - The counter is cleared to 0 and the state moves to EXPAND.
- **EXPAND.** Each cycle performs `ROUNDS_PER_CYCLE` chained round computations.
  - The chain starts from the last completed round key.
  - Round r uses the Rcon sequence 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Each result is written to its slot and the counter increments.
  - When the counter reaches `STEPS-1`, the state moves to DONE.
- **DONE.** `o_valid` is 1 and `o_key_schedule` holds until `i_valid`... more precisely, until `i_ready` is sampled high.
  - `i_ready` high with no new accept: the state returns to IDLE.
  - `i_ready` high with `i_valid` high: the new key is accepted and the state moves to EXPAND.
- `o_busy` is 1 in EXPAND only.
- `i_valid` during EXPAND is ignored because `o_ready` is 0. `i_key` is sampled only on accept.
- While `o_valid` is 0, `o_key_schedule` content is undefined for consumers. The bench checks it only when `o_valid` is 1.
- **Reset.** `rst` forces IDLE at any time, including mid-expansion, and aborts any expansion in progress.
- **Reset values:** `o_valid` 0, `o_busy` 0, `o_key_schedule` all zeros, `o_ready` 1, counter 0, and `o_rk_valid`, `o_rk_idx`, `o_rk` all 0.

## Timing
- With the accept sampled at edge 0, `o_valid` is 1 from cycle `STEPS+1`:
  - `ROUNDS_PER_CYCLE` = 1: cycle 11.
  - `ROUNDS_PER_CYCLE` = 2: cycle 6.
  - `ROUNDS_PER_CYCLE` = 5: cycle 3.
  - `ROUNDS_PER_CYCLE` = 10: cycle 2.
- Sustained throughput is one key per `STEPS+1` cycles when `i_ready` is held high.
- `o_key_schedule` is driven directly from a register, with no combinational path from inputs.
- The critical path is `ROUNDS_PER_CYCLE` chained rounds. Each round is one SubWord S-box layer plus an XOR chain.

## Configuration
- Macro `AES_KEY_EXPANDER_STREAM_EN`.
- **Defined:** the stream ports exist. In each EXPAND cycle, `o_rk_valid` pulses 1 for one cycle, registered with the schedule write.
  - `o_rk` is the highest-numbered round key produced that step, and `o_rk_idx` is its round number.
  - With `ROUNDS_PER_CYCLE` = 1, the indices are 1..10 on consecutive cycles.
  - Consumers can begin round 1 before the full schedule is complete.
- **Undefined:** the stream ports and their registers are absent. All other behaviour is identical.

## Structure
- **Package `aes_pkg`:**
  - the S-box constant array;
  - the `RCON[1:10]` constant;
  - `typedef logic [0:127] aes_key_t`;
  - `typedef logic [0:1407] aes_schedule_t`;
  - the state enum `aes_kx_state_e` (IDLE/EXPAND/DONE).
- **Sub-module `aes_key_round`:** combinational, computing one round key from the previous round key and its Rcon (RotWord, SubWord, Rcon XOR, word XOR chain). It is instantiated `ROUNDS_PER_CYCLE` times in a generate chain.
- **Top level:** the FSM, the counter, the schedule register, slot write-select, and the stream logic.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `ROUNDS_PER_CYCLE` = 1: `o_valid` at cycle 11; round 1 = `a0fafe1788542cb123a339392a6c7605`; round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- All-zero key, `ROUNDS_PER_CYCLE` = 5: `o_valid` at cycle 3; round 1 = `62636363626363636263636362636363`; round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Backpressure: hold `i_ready` at 0 for 5 cycles in DONE. Required response: `o_valid` and the schedule stay stable and `o_ready` stays 0. Then raise `i_ready` with `i_valid` 1: the new key is accepted, `o_valid` drops the next cycle, and it returns `STEPS+1` cycles after that accept.
- Reset mid-expansion: assert `rst` at cycle 5 of EXPAND. Required response: `o_valid` 0, `o_busy` 0, schedule all zeros, `o_ready` 1. A following FIPS key then expands correctly.
- `i_valid` pulsed during EXPAND with a different key: it is ignored and the schedule matches the first key.
- `AES_KEY_EXPANDER_STREAM_EN`, `ROUNDS_PER_CYCLE` = 2, FIPS key: exactly 5 `o_rk_valid` pulses, with `o_rk_idx` = 2, 4, 6, 8, 10 and `o_rk` equal to the matching schedule slot.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-expansion types and constants: S-box, round constants,
// key/schedule containers and the expander state encoding.
package aes_pkg;

  typedef logic [0:127]  aes_key_t;
  typedef logic [0:1407] aes_schedule_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_kx_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range round numbers only occur on idle lanes; they get a harmless zero.
  function automatic logic [7:0] rcon_of(input int r);
    if (r >= 1 && r <= 10) return RCON[r[3:0]];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-schedule round: RotWord, SubWord, Rcon XOR, then the
// four-word XOR chain producing the next round key.
module aes_key_round
  import aes_pkg::*;
(
  input  aes_key_t   prev_i,
  input  logic [7:0] rcon_i,
  output aes_key_t   next_o
);

  logic [0:31] w3, rot, sub, t;
  logic [0:31] n0, n1, n2, n3;

  assign w3  = prev_i[96:127];
  assign rot = {w3[8:31], w3[0:7]};
  assign sub = {SBOX[rot[0:7]], SBOX[rot[8:15]], SBOX[rot[16:23]], SBOX[rot[24:31]]};
  assign t   = sub ^ {rcon_i, 24'h000000};

  assign n0 = prev_i[0:31]  ^ t;
  assign n1 = prev_i[32:63] ^ n0;
  assign n2 = prev_i[64:95] ^ n1;
  assign n3 = w3            ^ n2;

  assign next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expander, ROUNDS_PER_CYCLE chained rounds per clock.
// Optional per-step round-key streaming ports under AES_KEY_EXPANDER_STREAM_EN.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [0:127]  i_key,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [0:1407] o_key_schedule,
  output logic          o_busy
`ifdef AES_KEY_EXPANDER_STREAM_EN
  ,
  output logic          o_rk_valid,
  output logic [3:0]    o_rk_idx,
  output logic [0:127]  o_rk
`endif
);

  localparam int STEPS = 10 / ROUNDS_PER_CYCLE;

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes_key_expander: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  aes_kx_state_e state_q;
  logic [3:0]    cnt_q;
  logic          valid_q, busy_q;
  aes_schedule_t sched_q, sched_d;
  logic          accept;
  int            base;

  aes_key_t rk_in [ROUNDS_PER_CYCLE];
  aes_key_t rk    [ROUNDS_PER_CYCLE];

  assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign accept  = i_valid && o_ready;

  // base is the round number of the last completed key; this step writes base+1..base+RPC.
  assign base     = int'(cnt_q) * ROUNDS_PER_CYCLE;
  assign rk_in[0] = sched_q[128*base +: 128];

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    if (j > 0) begin : g_chain
      assign rk_in[j] = rk[j-1];
    end
    aes_key_round u_round (
      .prev_i (rk_in[j]),
      .rcon_i (rcon_of(base + j + 1)),
      .next_o (rk[j])
    );
  end

  always_comb begin
    sched_d = sched_q;
    if (accept) begin
      sched_d = {i_key, 1280'b0};
    end else if (state_q == EXPAND) begin
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
        sched_d[128*(base+j+1) +: 128] = rk[j];
      end
    end
  end

`ifdef AES_KEY_EXPANDER_STREAM_EN
  logic         rk_valid_q;
  logic [3:0]   rk_idx_q;
  aes_key_t     rk_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sched_q <= '0;
`ifdef AES_KEY_EXPANDER_STREAM_EN
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_q       <= '0;
`endif
    end else begin
      sched_q <= sched_d;
`ifdef AES_KEY_EXPANDER_STREAM_EN
      rk_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXPAND;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        EXPAND: begin
`ifdef AES_KEY_EXPANDER_STREAM_EN
          rk_valid_q <= 1'b1;
          rk_idx_q   <= 4'(base + ROUNDS_PER_CYCLE);
          rk_q       <= rk[ROUNDS_PER_CYCLE-1];
`endif
          if (cnt_q == 4'(STEPS - 1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (i_valid) begin
              state_q <= EXPAND;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid        = valid_q;
  assign o_busy         = busy_q;
  assign o_key_schedule = sched_q;

`ifdef AES_KEY_EXPANDER_STREAM_EN
  assign o_rk_valid = rk_valid_q;
  assign o_rk_idx   = rk_idx_q;
  assign o_rk       = rk_q;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: a 1-round/cycle instance plus an
// auxiliary instance (5 rounds/cycle, or 2 with AES_KEY_EXPANDER_STREAM_EN).
module tb_aes_key_expander;

`ifdef AES_KEY_EXPANDER_STREAM_EN
  localparam int AUX_RPC = 2;
`else
  localparam int AUX_RPC = 5;
`endif

  int steps [2] = '{10, 10 / AUX_RPC};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid [2];
  logic          in_ready [2];
  logic [0:127]  in_key   [2];
  logic          o_rdy    [2];
  logic          o_vld    [2];
  logic          o_bsy    [2];
  logic [0:1407] o_sch    [2];

`ifdef AES_KEY_EXPANDER_STREAM_EN
  logic         m_rkv, a_rkv;
  logic [3:0]   m_idx, a_idx;
  logic [0:127] m_rk, a_rk;
`endif

  aes_key_expander #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .i_valid(in_valid[0]), .o_ready(o_rdy[0]), .i_key(in_key[0]),
    .o_valid(o_vld[0]), .i_ready(in_ready[0]), .o_key_schedule(o_sch[0]), .o_busy(o_bsy[0])
`ifdef AES_KEY_EXPANDER_STREAM_EN
    , .o_rk_valid(m_rkv), .o_rk_idx(m_idx), .o_rk(m_rk)
`endif
  );

  aes_key_expander #(.ROUNDS_PER_CYCLE(AUX_RPC)) u_aux (
    .clk(clk), .rst(rst), .i_valid(in_valid[1]), .o_ready(o_rdy[1]), .i_key(in_key[1]),
    .o_valid(o_vld[1]), .i_ready(in_ready[1]), .o_key_schedule(o_sch[1]), .o_busy(o_bsy[1])
`ifdef AES_KEY_EXPANDER_STREAM_EN
    , .o_rk_valid(a_rkv), .o_rk_idx(a_idx), .o_rk(a_rk)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Independent reference: S-box derived from GF(2^8) inversion plus affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256 && v != 0; c++)
        if (gmul(v[7:0], c[7:0]) == 8'h01) inv = c[7:0];
      b = inv;
      sb[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] model_sched(input logic [0:127] k);
    logic [0:31]   w [44];
    logic [0:31]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1407] s;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[8:31], t[0:7]};
        t = {sb[t[0:7]], sb[t[8:15]], sb[t[16:23]], sb[t[24:31]]};
        t[0:7] = t[0:7] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  function automatic logic [0:127] slot(input logic [0:1407] s, input int k);
    return s[128*k +: 128];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [0:1407] sched;
    int            acc;
  } sb_t;
  sb_t sbq[$];
  int  last_acc;

  typedef struct {
    logic [0:127] key;
    logic [0:127] rk1;
    logic [0:127] rk10;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key until accepted; on accept push its expected schedule.
  task automatic start_key(input int d, input logic [0:127] k);
    bit acc = 1'b0;
    sb_t e;
    in_valid[d] = 1'b1;
    in_key[d]   = k;
    #1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = o_rdy[d];
      tick();
    end
    in_valid[d] = 1'b0;
    in_ready[d] = 1'b0;
    #1;
    if (!acc) begin
      chk("accept timeout", 0, 1);
      return;
    end
    e.sched  = model_sched(k);
    e.acc    = cyc;
    last_acc = cyc;
    sbq.push_back(e);
    chk($sformatf("d%0d busy after accept", d), o_bsy[d], 1);
    chk($sformatf("d%0d ready after accept", d), o_rdy[d], 0);
    chk($sformatf("d%0d valid after accept", d), o_vld[d], 0);
  endtask

  task automatic wait_check(input int d, input string tag);
    bit  got = 1'b0;
    sb_t e;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = o_vld[d];
    end
    if (!got) begin
      chk({tag, " valid timeout"}, 0, 1);
      if (sbq.size() != 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, " latency"}, 128'(cyc - e.acc), 128'(steps[d]));
    for (int k = 0; k < 11; k++)
      chk($sformatf("%s slot%0d", tag, k), slot(o_sch[d], k), slot(e.sched, k));
  endtask

  task automatic release_out(input int d);
    in_ready[d] = 1'b1;
    tick();
    in_ready[d] = 1'b0;
    #1;
    chk($sformatf("d%0d valid after release", d), o_vld[d], 0);
    chk($sformatf("d%0d ready after release", d), o_rdy[d], 1);
  endtask

`ifdef AES_KEY_EXPANDER_STREAM_EN
  typedef struct {
    int           stamp;
    logic [3:0]   idx;
    logic [0:127] rk;
  } rk_rec_t;
  rk_rec_t rkq[$];
  always @(negedge clk) begin
    if (a_rkv) rkq.push_back('{cyc, a_idx, a_rk});
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:1407] m, held;
    logic [0:127]  k;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_ready[d] = 1'b0;
      in_key[d]   = '0;
    end
    build_sbox();
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 2; i < 4; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      m = model_sched(k);
      vecs[i] = '{k, slot(m, 1), slot(m, 10)};
    end

    // Reset state
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst valid", d), o_vld[d], 0);
      chk($sformatf("d%0d rst busy", d), o_bsy[d], 0);
      chk($sformatf("d%0d rst ready", d), o_rdy[d], 1);
      chk($sformatf("d%0d rst sched zero", d), o_sch[d] == '0, 1);
    end
`ifdef AES_KEY_EXPANDER_STREAM_EN
    chk("rst rk_valid", a_rkv, 0);
    chk("rst rk_idx", a_idx, 0);
    chk("rst rk", a_rk, 0);
`endif
    rst = 1'b0;
    tick();

    // Table of keys through the 1-round/cycle engine
    for (int i = 0; i < 4; i++) begin
      start_key(0, vecs[i].key);
      wait_check(0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d rk1", i), slot(o_sch[0], 1), vecs[i].rk1);
      chk($sformatf("vec%0d rk10", i), slot(o_sch[0], 10), vecs[i].rk10);
      release_out(0);
    end

    // Backpressure in DONE, then accept a new key straight out of DONE
    start_key(0, vecs[0].key);
    wait_check(0, "bp first");
    held = o_sch[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d valid", i), o_vld[0], 1);
      chk($sformatf("bp%0d ready", i), o_rdy[0], 0);
      chk($sformatf("bp%0d sched stable", i), o_sch[0] == held, 1);
    end
    in_ready[0] = 1'b1;
    #1;
    chk("bp ready follows i_ready", o_rdy[0], 1);
    start_key(0, vecs[1].key);
    wait_check(0, "bp second");
    release_out(0);

    // Asynchronous reset in the middle of an expansion
    start_key(0, vecs[0].key);
    void'(sbq.pop_back());
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst valid", o_vld[0], 0);
    chk("midrst busy", o_bsy[0], 0);
    chk("midrst ready", o_rdy[0], 1);
    chk("midrst sched zero", o_sch[0] == '0, 1);
    tick();
    tick();
    rst = 1'b0;
    start_key(0, vecs[0].key);
    wait_check(0, "after rst");
    release_out(0);

    // A second key offered during EXPAND must be ignored
    start_key(0, vecs[2].key);
    tick();
    tick();
    in_valid[0] = 1'b1;
    in_key[0]   = vecs[3].key;
    tick();
    chk("ignore ready low", o_rdy[0], 0);
    tick();
    in_valid[0] = 1'b0;
    wait_check(0, "ignore");
    release_out(0);

    // Auxiliary engine: all-zero key, then FIPS key
    start_key(1, vecs[1].key);
    wait_check(1, "aux zero");
    chk("aux zero rk1", slot(o_sch[1], 1), vecs[1].rk1);
    chk("aux zero rk10", slot(o_sch[1], 10), vecs[1].rk10);
    release_out(1);

    start_key(1, vecs[0].key);
    wait_check(1, "aux fips");
    release_out(1);
`ifdef AES_KEY_EXPANDER_STREAM_EN
    begin
      int n = 0;
      m = model_sched(vecs[0].key);
      foreach (rkq[i]) begin
        if (rkq[i].stamp > last_acc) begin
          chk($sformatf("stream%0d idx", n), rkq[i].idx, 128'((n + 1) * AUX_RPC));
          chk($sformatf("stream%0d rk", n), rkq[i].rk, slot(m, (n + 1) * AUX_RPC));
          n++;
        end
      end
      chk("stream pulse count", 128'(n), 128'(steps[1]));
    end
`endif

    chk("scoreboard drained", 128'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
